// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions: stage FSM states, MIPS register-field positions
// and the default bubble instruction.
package pipeline_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY = 2'd0,
    ST_FULL  = 2'd1,
    ST_SKID  = 2'd2
  } stage_state_e;

  localparam int REG_FIELD_W = 5;

  localparam int RS_MSB = 25;
  localparam int RS_LSB = 21;
  localparam int RT_MSB = 20;
  localparam int RT_LSB = 16;
  localparam int RD_MSB = 15;
  localparam int RD_LSB = 11;

  localparam logic [31:0] NOP_INSTR_DEFAULT = 32'h0000_0000;

endpackage

// File: rtl/if_id_skid_stage_if.sv
// Valid/ready stream carrying one fetched PC and instruction.
// The producer uses the master modport and the consumer uses the slave modport.
interface if_id_skid_stage_if #(
  parameter int NBITS   = 32,
  parameter int PC_BITS = 32
);
  logic               valid;
  logic               ready;
  logic [PC_BITS-1:0] pc;
  logic [NBITS-1:0]   instruction;

  modport master (
    output valid,
    output pc,
    output instruction,
    input  ready
  );

  modport slave (
    input  valid,
    input  pc,
    input  instruction,
    output ready
  );
endinterface

// File: rtl/if_id_skid_stage.sv
// IF/ID pipeline register with a one-entry skid buffer, branch flush, sticky halt
// and a global step enable. Register fields are sliced straight from the output register.
module if_id_skid_stage
  import pipeline_pkg::*;
#(
  parameter int               NBITS     = 32,
  parameter int               PC_BITS   = 32,
  parameter logic [NBITS-1:0] NOP_INSTR = NBITS'(NOP_INSTR_DEFAULT)
) (
  input  logic                   i_clk,
  input  logic                   i_reset,
  input  logic                   i_enable,
  input  logic                   i_flush,
  input  logic                   i_halt,
  if_id_skid_stage_if.slave      fetch,
  if_id_skid_stage_if.master     decode,
  output logic [REG_FIELD_W-1:0] o_rs,
  output logic [REG_FIELD_W-1:0] o_rt,
  output logic [REG_FIELD_W-1:0] o_rd,
  output logic                   o_halted
);

  stage_state_e       state_q, state_d;
  logic [PC_BITS-1:0] out_pc_q, skid_pc_q;
  logic [NBITS-1:0]   out_instr_q, skid_instr_q;
  logic               halted_q;

  logic ready_int, in_fire, out_fire;
  logic load_out, move_skid, clear_out, load_skid, clear_skid, set_halt;

  assign ready_int = i_enable & ~i_reset & ~halted_q & (state_q != ST_SKID);
  assign in_fire   = fetch.valid & ready_int;
  assign out_fire  = (state_q != ST_EMPTY) & decode.ready & i_enable;

  // Flush wins over every other event, including a same-cycle halt or input.
  always_comb begin
    state_d    = state_q;
    load_out   = 1'b0;
    move_skid  = 1'b0;
    clear_out  = 1'b0;
    load_skid  = 1'b0;
    clear_skid = 1'b0;
    set_halt   = 1'b0;
    if (i_enable) begin
      if (i_flush) begin
        state_d    = ST_EMPTY;
        clear_out  = 1'b1;
        clear_skid = 1'b1;
      end else begin
        set_halt = i_halt;
        unique case (state_q)
          ST_EMPTY: begin
            if (in_fire) begin
              state_d  = ST_FULL;
              load_out = 1'b1;
            end
          end
          ST_FULL: begin
            if (in_fire && out_fire) begin
              load_out = 1'b1;
            end else if (in_fire) begin
              state_d   = ST_SKID;
              load_skid = 1'b1;
            end else if (out_fire) begin
              state_d   = ST_EMPTY;
              clear_out = 1'b1;
            end
          end
          ST_SKID: begin
            if (out_fire) begin
              state_d    = ST_FULL;
              move_skid  = 1'b1;
              clear_skid = 1'b1;
            end
          end
          default: state_d = ST_EMPTY;
        endcase
      end
    end
  end

  // Clearing the output register on entry to EMPTY makes the bubble payload automatic.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q      <= ST_EMPTY;
      out_pc_q     <= '0;
      out_instr_q  <= NOP_INSTR;
      skid_pc_q    <= '0;
      skid_instr_q <= NOP_INSTR;
      halted_q     <= 1'b0;
    end else begin
      state_q <= state_d;
      if (clear_out) begin
        out_pc_q    <= '0;
        out_instr_q <= NOP_INSTR;
      end else if (load_out) begin
        out_pc_q    <= fetch.pc;
        out_instr_q <= fetch.instruction;
      end else if (move_skid) begin
        out_pc_q    <= skid_pc_q;
        out_instr_q <= skid_instr_q;
      end
      if (clear_skid) begin
        skid_pc_q    <= '0;
        skid_instr_q <= NOP_INSTR;
      end else if (load_skid) begin
        skid_pc_q    <= fetch.pc;
        skid_instr_q <= fetch.instruction;
      end
      if (set_halt) begin
        halted_q <= 1'b1;
      end
    end
  end

  assign fetch.ready        = ready_int;
  assign decode.valid       = (state_q != ST_EMPTY);
  assign decode.pc          = out_pc_q;
  assign decode.instruction = out_instr_q;
  assign o_rs               = out_instr_q[RS_MSB:RS_LSB];
  assign o_rt               = out_instr_q[RT_MSB:RT_LSB];
  assign o_rd               = out_instr_q[RD_MSB:RD_LSB];
  assign o_halted           = halted_q;

endmodule

// File: tb/tb_if_id_skid_stage.sv
// Self-checking bench for if_id_skid_stage: directed vector table, hand-written corner
// sequences, then random traffic checked against a two-entry queue model.
module tb_if_id_skid_stage;
  import pipeline_pkg::*;

  localparam int NB = 32;
  localparam int PB = 32;

  typedef struct {
    logic        rst, en, fl, hl, v, rdy;
    logic [31:0] pc, ins;
    logic        exp_ready, exp_valid;
    logic [31:0] exp_pc, exp_ins;
    logic        exp_halted;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset = 1'b1, enable = 1'b0, flush = 1'b0, halt = 1'b0;
  logic [4:0] rs, rt, rd;
  logic       halted;

  if_id_skid_stage_if #(.NBITS(NB), .PC_BITS(PB)) fetch_bus ();
  if_id_skid_stage_if #(.NBITS(NB), .PC_BITS(PB)) decode_bus ();

  if_id_skid_stage #(.NBITS(NB), .PC_BITS(PB), .NOP_INSTR(32'h0)) dut (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_enable (enable),
    .i_flush  (flush),
    .i_halt   (halt),
    .fetch    (fetch_bus),
    .decode   (decode_bus),
    .o_rs     (rs),
    .o_rt     (rt),
    .o_rd     (rd),
    .o_halted (halted)
  );

  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;

  logic [63:0] model_q[$];
  logic        model_halted;

  function automatic vec_t mkv(input logic rst, en, fl, hl, v, rdy,
                               input logic [31:0] pc, ins,
                               input logic er, ev,
                               input logic [31:0] epc, eins,
                               input logic eh);
    vec_t t;
    t.rst = rst; t.en = en; t.fl = fl; t.hl = hl; t.v = v; t.rdy = rdy;
    t.pc = pc; t.ins = ins;
    t.exp_ready = er; t.exp_valid = ev; t.exp_pc = epc; t.exp_ins = eins;
    t.exp_halted = eh;
    return t;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t t);
    @(negedge clk);
    reset                 = t.rst;
    enable                = t.en;
    flush                 = t.fl;
    halt                  = t.hl;
    fetch_bus.valid       = t.v;
    fetch_bus.pc          = t.pc;
    fetch_bus.instruction = t.ins;
    decode_bus.ready      = t.rdy;
  endtask

  task automatic runVector(input string tag, input vec_t t);
    logic [31:0] eins;
    eins = t.exp_ins;
    applyStimulus(t);
    #1;
    checkOutput({tag, " ready"}, 32'(fetch_bus.ready), 32'(t.exp_ready));
    @(posedge clk);
    #1;
    checkOutput({tag, " valid"}, 32'(decode_bus.valid), 32'(t.exp_valid));
    checkOutput({tag, " pc"}, decode_bus.pc, t.exp_pc);
    checkOutput({tag, " instr"}, decode_bus.instruction, eins);
    checkOutput({tag, " rs"}, 32'(rs), 32'(eins[25:21]));
    checkOutput({tag, " rt"}, 32'(rt), 32'(eins[20:16]));
    checkOutput({tag, " rd"}, 32'(rd), 32'(eins[15:11]));
    checkOutput({tag, " halted"}, 32'(halted), 32'(t.exp_halted));
  endtask

  // The model sees the stage as a FIFO of at most two entries plus a halt flag.
  task automatic modelStep(inout vec_t t);
    logic in_ok, out_ok;
    t.exp_ready = !t.rst && t.en && !model_halted && (model_q.size() < 2);
    if (t.rst) begin
      model_q.delete();
      model_halted = 1'b0;
    end else if (t.en) begin
      if (t.fl) begin
        model_q.delete();
      end else begin
        out_ok = (model_q.size() > 0) && t.rdy;
        in_ok  = t.v && t.exp_ready;
        if (out_ok) void'(model_q.pop_front());
        if (in_ok) model_q.push_back({t.pc, t.ins});
        if (t.hl) model_halted = 1'b1;
      end
    end
    t.exp_valid  = (model_q.size() > 0);
    t.exp_pc     = t.exp_valid ? model_q[0][63:32] : 32'h0;
    t.exp_ins    = t.exp_valid ? model_q[0][31:0] : 32'h0;
    t.exp_halted = model_halted;
  endtask

  vec_t stream_tbl[10];

  initial begin
    vec_t rv;
    fetch_bus.valid = 1'b0;
    fetch_bus.pc = '0;
    fetch_bus.instruction = '0;
    decode_bus.ready = 1'b0;

    // rst en fl hl v rdy pc ins | ready valid pc ins halted
    stream_tbl[0] = mkv(1,0,0,0,0,0, 32'd0,  32'h0,         0,0, 32'd0,  32'h0,         0);
    stream_tbl[1] = mkv(0,1,0,0,1,1, 32'd4,  32'h2002_0005, 1,1, 32'd4,  32'h2002_0005, 0);
    stream_tbl[2] = mkv(0,1,0,0,1,1, 32'd8,  32'h2002_0006, 1,1, 32'd8,  32'h2002_0006, 0);
    stream_tbl[3] = mkv(0,1,0,0,1,1, 32'd12, 32'h2002_0007, 1,1, 32'd12, 32'h2002_0007, 0);
    stream_tbl[4] = mkv(0,1,0,0,1,0, 32'd16, 32'h2002_0008, 1,1, 32'd12, 32'h2002_0007, 0);
    stream_tbl[5] = mkv(0,1,0,0,1,0, 32'd20, 32'h2002_0009, 0,1, 32'd12, 32'h2002_0007, 0);
    stream_tbl[6] = mkv(0,1,0,0,1,0, 32'd20, 32'h2002_0009, 0,1, 32'd12, 32'h2002_0007, 0);
    stream_tbl[7] = mkv(0,1,0,0,1,1, 32'd20, 32'h2002_0009, 0,1, 32'd16, 32'h2002_0008, 0);
    stream_tbl[8] = mkv(0,1,0,0,1,1, 32'd20, 32'h2002_0009, 1,1, 32'd20, 32'h2002_0009, 0);
    stream_tbl[9] = mkv(0,1,0,0,0,1, 32'd0,  32'h0,         1,0, 32'd0,  32'h0,         0);

    for (int i = 0; i < 10; i++) runVector($sformatf("stream[%0d]", i), stream_tbl[i]);

    // Flush while the skid is full, with a valid input in the flush cycle.
    runVector("flush0", mkv(1,1,0,0,0,0, 32'h0,  32'h0,  0,0, 32'h0,  32'h0,  0));
    runVector("flush1", mkv(0,1,0,0,1,0, 32'h40, 32'hA0, 1,1, 32'h40, 32'hA0, 0));
    runVector("flush2", mkv(0,1,0,0,1,0, 32'h44, 32'hA1, 1,1, 32'h40, 32'hA0, 0));
    runVector("flush3", mkv(0,1,1,0,1,0, 32'h48, 32'hA2, 0,0, 32'h0,  32'h0,  0));
    runVector("flush4", mkv(0,1,0,0,1,1, 32'h4C, 32'hA3, 1,1, 32'h4C, 32'hA3, 0));
    runVector("flush5", mkv(0,1,0,0,0,1, 32'h0,  32'h0,  1,0, 32'h0,  32'h0,  0));

    // Enable freeze while FULL with both handshakes asserted.
    runVector("freeze0", mkv(0,1,0,0,1,1, 32'h60, 32'hB0, 1,1, 32'h60, 32'hB0, 0));
    for (int i = 1; i <= 4; i++)
      runVector($sformatf("freeze%0d", i),
                mkv(0,0,0,0,1,1, 32'h64, 32'hB1, 0,1, 32'h60, 32'hB0, 0));
    runVector("freeze5", mkv(0,1,0,0,1,1, 32'h64, 32'hB1, 1,1, 32'h64, 32'hB1, 0));
    runVector("freeze6", mkv(0,1,0,0,1,1, 32'h68, 32'hB2, 1,1, 32'h68, 32'hB2, 0));
    runVector("freeze7", mkv(0,1,0,0,0,1, 32'h0,  32'h0,  1,0, 32'h0,  32'h0,  0));

    // Sticky halt: the halt instruction itself is accepted, then intake stops.
    runVector("halt1", mkv(0,1,0,1,1,0, 32'h100, 32'hFFFF_FFFF, 1,1, 32'h100, 32'hFFFF_FFFF, 1));
    runVector("halt2", mkv(0,1,0,0,1,0, 32'h104, 32'h1111_1111, 0,1, 32'h100, 32'hFFFF_FFFF, 1));
    runVector("halt3", mkv(0,1,0,0,1,1, 32'h104, 32'h1111_1111, 0,0, 32'h0,   32'h0,         1));
    runVector("halt4", mkv(0,1,1,0,1,1, 32'h104, 32'h1111_1111, 0,0, 32'h0,   32'h0,         1));
    runVector("halt5", mkv(1,1,0,0,0,1, 32'h0,   32'h0,         0,0, 32'h0,   32'h0,         0));
    runVector("halt6", mkv(0,1,0,0,1,1, 32'h200, 32'h1234_5678, 1,1, 32'h200, 32'h1234_5678, 0));
    runVector("halt7", mkv(0,1,0,0,0,1, 32'h0,   32'h0,         1,0, 32'h0,   32'h0,         0));

    // Reset while the skid holds an entry.
    runVector("rst1", mkv(0,1,0,0,1,0, 32'h80, 32'hC0, 1,1, 32'h80, 32'hC0, 0));
    runVector("rst2", mkv(0,1,0,0,1,0, 32'h84, 32'hC1, 1,1, 32'h80, 32'hC0, 0));
    runVector("rst3", mkv(1,1,0,0,1,0, 32'h88, 32'hC2, 0,0, 32'h0,  32'h0,  0));
    runVector("rst4", mkv(0,1,0,0,0,1, 32'h0,  32'h0,  1,0, 32'h0,  32'h0,  0));

    model_q.delete();
    model_halted = 1'b0;
    for (int c = 0; c < 1500; c++) begin
      rv.rst = (c == 0) || ($urandom_range(0, 29) == 0);
      rv.en  = ($urandom_range(0, 99) < 85);
      rv.fl  = ($urandom_range(0, 14) == 0);
      rv.hl  = ($urandom_range(0, 59) == 0);
      rv.v   = ($urandom_range(0, 99) < 70);
      rv.rdy = ($urandom_range(0, 99) < 60);
      rv.pc  = $urandom;
      rv.ins = $urandom;
      modelStep(rv);
      runVector($sformatf("rand[%0d]", c), rv);
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule

// File: doc/if_id_skid_stage.md
# if_id_skid_stage

Parametrised IF/ID pipeline stage carrying fetched PC and instruction from fetch to decode with a valid/ready handshake and a one-entry skid buffer. It sustains one instruction per cycle under backpressure. It supports branch flush (bubble insertion), sticky halt, and a global step enable for the debug unit. It also exposes pre-sliced rs/rt/rd register fields at their correct 5-bit width.

## Interface
- `NBITS`, 32, instruction width (≥ 26)
- `PC_BITS`, 32, PC width
- `NOP_INSTR`, `{NBITS{1'b0}}`, bubble encoding driven when `o_valid` = 0
- `i_clk` in 1: clock
- `i_reset` in 1: synchronous, active-high reset
- `i_enable` in 1: global step enable; 0 freezes all state
- `i_flush` in 1: branch/jump redirect; discard stage contents
- `i_halt` in 1: halt instruction detected; stop accepting
- `i_valid` in 1: fetch presents a valid instruction
- `o_ready` out 1: stage can accept this cycle
- `i_pc` in `PC_BITS`: next-PC of the fetched instruction
- `i_instruction` in `NBITS`: fetched instruction
- `o_valid` out 1: decode-side payload valid
- `i_ready` in 1: decode can consume (0 = hazard stall)
- `o_pc` out `PC_BITS`: registered PC
- `o_instruction` out `NBITS`: registered instruction
- `o_rs`, `o_rt`, `o_rd` out 5 each: `o_instruction[25:21]`, `[20:16]`, `[15:11]`
- `o_halted` out 1: sticky halt flag

## Operation
- States:
  - EMPTY: output register invalid.
  - FULL: output register valid, skid empty.
  - SKID: output register valid, skid holds one entry.
- Signal definitions:
  - in_fire = `i_valid` & `o_ready`.
  - out_fire = `o_valid` & `i_ready` & `i_enable`.
  - `o_ready` = `i_enable` & !halted & (state != SKID), combinational.
- Transitions (`i_enable`=1, no flush):
  - EMPTY: on in_fire, go to FULL and load the output register.
  - FULL: in_fire & out_fire: stay FULL, load new. in_fire only: go to SKID, store into skid. out_fire only: go to EMPTY.
  - SKID: on out_fire, move skid to the output register and go to FULL. No input is accepted in SKID.
- Flush (`i_flush`=1 & `i_enable`=1):
  - Go to EMPTY and drop skid and output contents.
  - A same-cycle input is discarded, even if `i_valid`=1.
  - Flush has priority over everything except reset.
- Halt (`i_halt`=1 & `i_enable`=1):
  - halted ← 1, sticky until reset.
  - A same-cycle in_fire is still accepted (the halt instruction itself).
  - Afterwards `o_ready`=0, while existing contents still drain normally.
  - Flush while halted clears contents; halted stays 1.
- Bubble rule: whenever `o_valid`=0, `o_instruction`=`NOP_INSTR` and `o_pc`=0. The registers are loaded with these on a transition to EMPTY.
- `i_enable`=0: no state, payload or flag changes. `o_ready`=0, and `o_valid`/payload hold.

## Timing
- Reset values: state EMPTY, `o_valid`=0, `o_ready`=0 during reset, `o_pc`=0, `o_instruction`=`NOP_INSTR`, `o_rs`/`o_rt`/`o_rd` = fields of `NOP_INSTR`, `o_halted`=0, skid cleared.
- Latency: 1 cycle from in_fire to `o_valid` with that payload.
- Throughput: 1 per cycle while `i_ready`=1.
- `o_ready` falls the cycle after the skid fills. A backpressure edge loses no data.
- Reset mid-operation discards both entries in the next cycle.
- `o_rs`/`o_rt`/`o_rd` are combinational slices of the output register, with no extra latency.

## Structure
- Shared package `pipeline_pkg`:
  - state enum (EMPTY/FULL/SKID)
  - `RS_MSB`/`RS_LSB`, `RT_MSB`/`RT_LSB`, `RD_MSB`/`RD_LSB` field constants
  - default `NOP_INSTR`
  - register-field width constant (5)
- No sub-module. The skid slot is a single register pair in this module, so a separate module adds nothing.

## Test plan
- Stream: `i_valid`=1 and `i_ready`=1 for instructions 0x2002_0005…0x2002_0009 with PC 4,8,…,20. Required: `o_valid` 1 cycle later with the same order and values, `o_ready` held at 1, and `o_rs`=0, `o_rt`=2 for 0x2002_0005.
- Backpressure: drop `i_ready` for 3 cycles mid-stream. Required: one instruction captured in skid, `o_ready`=0 from the next cycle, no loss or duplication after `i_ready` returns.
- Flush: assert `i_flush` while in SKID with `i_valid`=1. Required: next cycle `o_valid`=0, `o_instruction`=`NOP_INSTR`, `o_pc`=0, and the flushed-cycle input never appears.
- Halt: accept 0xFFFF_FFFF with `i_halt`=1. Required: it reaches `o_valid`, `o_halted`=1 sticky, `o_ready`=0 thereafter, and `o_halted` clears only on `i_reset`.
- Enable freeze: `i_enable`=0 for 4 cycles while FULL with `i_valid`=`i_ready`=1. Required: outputs unchanged, `o_ready`=0, and the stream resumes losslessly.
- Reset mid-stream in SKID: next cycle, all outputs equal the reset values.
